can_bit_timing_gen: RTL

//  Run-time-configurable CAN bit-timing engine: prescales clk to time quanta (tq), sequences

---
 rtl/can_timing_pkg.sv | 13 +
 rtl/can_bit_timing_gen_if.sv | 26 ++
 rtl/can_tq_prescaler.sv | 20 ++
 rtl/can_bit_timing_gen.sv | 79 +++++++
 4 files changed

// File: rtl/can_timing_pkg.sv
// can_timing_pkg: shared widths, bit-state encoding and helpers for the CAN bit-timing engine
// Provides default field widths, the IDLE/SYNC/TSEG1/TSEG2 encoding and an unsigned min.
package can_timing_pkg;
  localparam int BRP_W = 6;
  localparam int TSEG1_W = 4;
  localparam int TSEG2_W = 3;
  localparam int SJW_W = 2;
  localparam int CNT_W = (TSEG1_W > TSEG2_W ? TSEG1_W : TSEG2_W) + 1;
  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, TSEG1 = 2'd2, TSEG2 = 2'd3} bit_state_e;
  function automatic logic [CNT_W-1:0] umin(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    return a < b ? a : b;
  endfunction
endpackage

// File: rtl/can_bit_timing_gen_if.sv
// can_bit_timing_gen_if: config, rx and timing outputs of the CAN bit-timing engine
// master drives cfg_*/rx/hard_sync_en and observes the timing outputs; slave is the engine.
interface can_bit_timing_gen_if;
  import can_timing_pkg::*;
  logic               cfg_en;
  logic [BRP_W-1:0]   cfg_brp;
  logic [TSEG1_W-1:0] cfg_tseg1;
  logic [TSEG2_W-1:0] cfg_tseg2;
  logic [SJW_W-1:0]   cfg_sjw;
  logic               rx;
  logic               hard_sync_en;
  logic               tq_tick;
  logic               tx_point;
  logic               sample_pulse;
  logic               sample_bit;
  logic [1:0]         bit_state;
  logic               cfg_err;
  modport master (
    output cfg_en, cfg_brp, cfg_tseg1, cfg_tseg2, cfg_sjw, rx, hard_sync_en,
    input  tq_tick, tx_point, sample_pulse, sample_bit, bit_state, cfg_err
  );
  modport slave (
    input  cfg_en, cfg_brp, cfg_tseg1, cfg_tseg2, cfg_sjw, rx, hard_sync_en,
    output tq_tick, tx_point, sample_pulse, sample_bit, bit_state, cfg_err
  );
endinterface

// File: rtl/can_tq_prescaler.sv
// can_tq_prescaler: divides clk into time quanta of brp_i+1 cycles
// Ports: clk, rst; run_i enables counting; restart_i zeroes the count (hard sync);
// brp_i terminal count; tq_tick_o on the last clk of a tq; first_o on the first clk of a tq.
module can_tq_prescaler import can_timing_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             restart_i,
  input  logic [BRP_W-1:0] brp_i,
  output logic             tq_tick_o,
  output logic             first_o
);
  logic [BRP_W-1:0] cnt_q, cnt_d;
  always_comb begin
    tq_tick_o = run_i && cnt_q == brp_i;
    first_o = cnt_q == '0;
    cnt_d = (restart_i || !run_i || tq_tick_o) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/can_bit_timing_gen.sv
// can_bit_timing_gen: CAN bit-timing engine with hard sync and SJW-limited resync
// Ports: clk, rst (sync, active high); bus (slave) carries config, rx, hard_sync_en in
// and tq_tick, tx_point, sample_pulse, sample_bit, bit_state, cfg_err out.
module can_bit_timing_gen import can_timing_pkg::*; (
  input logic                 clk,
  input logic                 rst,
  can_bit_timing_gen_if.slave bus
);
  bit_state_e state_q, state_d;
  logic en_q, rx_q, err_q, rs_done_q, smp_done_q, smp_q, sbit_q;
  logic [BRP_W-1:0] brp_q;
  logic [CNT_W-1:0] t1_q, t2_q, sjw_q, tq_q, tq_d, adj_q, adj_n, adj_d;
  logic rise, bad, fall, hard, resync, tick, first, last1, last2, seg_end, smp, clr;
  can_tq_prescaler u_pre (
    .clk(clk), .rst(rst), .run_i(state_q != IDLE), .restart_i(hard),
    .brp_i(brp_q), .tq_tick_o(tick), .first_o(first)
  );
  // adj is the per-segment phase correction: added to the TSEG1 end, removed from the TSEG2 end.
  // It takes effect in the same clk as the edge so a resync on a tq_tick is not a tq late.
  always_comb begin
    rise = bus.cfg_en && !en_q;
    bad = CNT_W'(bus.cfg_tseg2) < CNT_W'(bus.cfg_sjw) || CNT_W'(bus.cfg_tseg1) < CNT_W'(bus.cfg_tseg2);
    fall = rx_q && !bus.rx && state_q != IDLE && bus.cfg_en;
    hard = fall && bus.hard_sync_en;
    resync = fall && !bus.hard_sync_en && !rs_done_q && (state_q == TSEG1 || state_q == TSEG2);
    adj_n = !resync ? adj_q : state_q == TSEG1 ? umin(tq_q + 1'b1, sjw_q) : umin(t2_q + 1'b1 - tq_q, sjw_q);
    last1 = tq_q == t1_q + adj_n;
    last2 = tq_q + adj_n >= t2_q;
    // the sample point stays at the pre-edge TSEG1 end; a late edge on that tick still lengthens TSEG1
    smp = tick && !hard && bus.cfg_en && state_q == TSEG1 && tq_q == t1_q + adj_q && !smp_done_q;
    seg_end = tick && (state_q == SYNC || (state_q == TSEG1 && last1) || (state_q == TSEG2 && last2));
    state_d = !bus.cfg_en ? IDLE : rise ? (bad ? IDLE : SYNC) : hard ? SYNC : !seg_end ? state_q :
              state_q == SYNC ? TSEG1 : state_q == TSEG1 ? TSEG2 : SYNC;
    clr = hard || seg_end || state_q == IDLE;
    tq_d = clr ? '0 : tick ? tq_q + 1'b1 : tq_q;
    adj_d = clr ? '0 : adj_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      en_q <= 1'b0;
      rx_q <= 1'b1;
      err_q <= 1'b0;
      rs_done_q <= 1'b0;
      smp_done_q <= 1'b0;
      smp_q <= 1'b0;
      sbit_q <= 1'b1;
      brp_q <= '0;
      t1_q <= '0;
      t2_q <= '0;
      sjw_q <= '0;
      tq_q <= '0;
      adj_q <= '0;
    end else begin
      state_q <= state_d;
      en_q <= bus.cfg_en;
      rx_q <= bus.rx;
      if (rise) begin
        brp_q <= bus.cfg_brp;
        t1_q <= CNT_W'(bus.cfg_tseg1);
        t2_q <= CNT_W'(bus.cfg_tseg2);
        sjw_q <= CNT_W'(bus.cfg_sjw) + 1'b1;
        err_q <= bad;
      end
      tq_q <= tq_d;
      adj_q <= adj_d;
      rs_done_q <= state_q != SYNC && (rs_done_q || resync);
      smp_done_q <= state_q != SYNC && (smp_done_q || smp);
      smp_q <= smp;
      if (smp) sbit_q <= bus.rx;
    end
  end
  assign bus.tq_tick = tick;
  assign bus.tx_point = state_q == SYNC && first;
  assign bus.sample_pulse = smp_q;
  assign bus.sample_bit = sbit_q;
  assign bus.bit_state = state_q;
  assign bus.cfg_err = err_q;
endmodule
